// File: rtl/bram_rd_arbiter.sv
// Read-port arbiter sharing one BRAM read request/response pair among n_clients.
// Define BRAM_RD_ARB_RR_EN for round-robin grant; otherwise lowest index wins.
module bram_rd_arbiter #(
    parameter int n_clients       = 4,
    parameter int addr_width      = 10,
    parameter int data_width      = 32,
    parameter int max_outstanding = 2
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [n_clients-1:0]            CL_REQ_EN,
    input  logic [n_clients*addr_width-1:0] CL_REQ_ADDR,
    output logic [n_clients-1:0]            CL_REQ_RDY,
    output logic [data_width-1:0]           CL_RSP,
    output logic [n_clients-1:0]            CL_RSP_RDY,
    input  logic [n_clients-1:0]            CL_RSP_EN,
    output logic [addr_width-1:0]           RD_ADDR,
    output logic                            RD_EN,
    input  logic                            RD_RDY,
    input  logic [data_width-1:0]           RES,
    input  logic                            RES_RDY,
    output logic                            RES_EN
);
    localparam int tag_w = (n_clients > 1) ? $clog2(n_clients) : 1;
    localparam int ptr_w = (max_outstanding > 1) ? $clog2(max_outstanding) : 1;
    localparam int cnt_w = $clog2(max_outstanding + 1);

    logic [tag_w-1:0] tag_q [max_outstanding];
    logic [tag_w-1:0] tag_d [max_outstanding];
    logic [ptr_w-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic [tag_w-1:0] rr_q, rr_d;

    logic             eligible, win_found, accept, push, pop;
    logic [tag_w-1:0] win_idx;

    // Acceptance depends only on registered occupancy, never on this cycle's pop.
    assign eligible = !RST && RD_RDY && (cnt_q < cnt_w'(max_outstanding));

`ifdef BRAM_RD_ARB_RR_EN
    logic [tag_w:0] scan;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 0; k < n_clients; k++) begin
            scan = {1'b0, rr_q} + (tag_w+1)'(k);
            if (scan >= (tag_w+1)'(n_clients)) scan = scan - (tag_w+1)'(n_clients);
            if (!win_found && CL_REQ_EN[scan[tag_w-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[tag_w-1:0];
            end
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = n_clients - 1; i >= 0; i--) begin
            if (CL_REQ_EN[i]) begin
                win_found = 1'b1;
                win_idx   = tag_w'(i);
            end
        end
    end
`endif

    assign accept = eligible && win_found;
    assign push   = accept;

    always_comb begin
        CL_REQ_RDY = '0;
        RD_ADDR    = '0;
        if (accept) CL_REQ_RDY[win_idx] = 1'b1;
        for (int i = 0; i < n_clients; i++) begin
            if (win_idx == tag_w'(i)) RD_ADDR = CL_REQ_ADDR[i*addr_width +: addr_width];
        end
    end

    assign RD_EN = accept;

    // Results come back strictly in order, so the FIFO head names the owner.
    always_comb begin
        CL_RSP_RDY = '0;
        if (!RST && RES_RDY && (cnt_q != '0)) CL_RSP_RDY[tag_q[rd_q]] = 1'b1;
    end

    assign CL_RSP = RES;
    assign pop    = |(CL_RSP_EN & CL_RSP_RDY);
    assign RES_EN = pop;

    always_comb begin
        tag_d = tag_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        rr_d  = rr_q;
        if (push) begin
            tag_d[wr_q] = win_idx;
            wr_d        = (wr_q == ptr_w'(max_outstanding - 1)) ? '0 : wr_q + 1'b1;
            rr_d        = (win_idx == tag_w'(n_clients - 1)) ? '0 : win_idx + 1'b1;
        end
        if (pop) rd_d = (rd_q == ptr_w'(max_outstanding - 1)) ? '0 : rd_q + 1'b1;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < max_outstanding; i++) tag_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            rr_q  <= '0;
        end else begin
            tag_q <= tag_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            rr_q  <= rr_d;
        end
    end

`ifndef SYNTHESIS
    a_res_rdy_nonempty: assert property (@(posedge CLK) disable iff (RST)
        RES_RDY |-> (cnt_q != '0));
    a_pop_nonempty: assert property (@(posedge CLK) disable iff (RST)
        RES_EN |-> (cnt_q != '0));
    // A dequeue from a client that is not at the head is dropped, but still flagged.
    a_rsp_en_without_rdy: assert property (@(posedge CLK) disable iff (RST)
        ((CL_RSP_EN & ~CL_RSP_RDY) == '0));
`endif
endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Bench for bram_rd_arbiter: constant grant vectors, directed corner sequences and
// random traffic against a queue-based model with a behavioural BRAM.
module tb_bram_rd_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MO = 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    CL_REQ_EN;
    logic [N*AW-1:0] CL_REQ_ADDR;
    logic [N-1:0]    CL_REQ_RDY;
    logic [DW-1:0]   CL_RSP;
    logic [N-1:0]    CL_RSP_RDY;
    logic [N-1:0]    CL_RSP_EN;
    logic [AW-1:0]   RD_ADDR;
    logic            RD_EN;
    logic            RD_RDY;
    logic [DW-1:0]   RES;
    logic            RES_RDY;
    logic            RES_EN;

    bram_rd_arbiter #(.n_clients(N), .addr_width(AW), .data_width(DW), .max_outstanding(MO)) dut (
        .CLK(CLK), .RST(RST),
        .CL_REQ_EN(CL_REQ_EN), .CL_REQ_ADDR(CL_REQ_ADDR), .CL_REQ_RDY(CL_REQ_RDY),
        .CL_RSP(CL_RSP), .CL_RSP_RDY(CL_RSP_RDY), .CL_RSP_EN(CL_RSP_EN),
        .RD_ADDR(RD_ADDR), .RD_EN(RD_EN), .RD_RDY(RD_RDY),
        .RES(RES), .RES_RDY(RES_RDY), .RES_EN(RES_EN)
    );

    always #5 CLK = ~CLK;

    logic [AW-1:0] addr [N];
    always_comb begin
        CL_REQ_ADDR = '0;
        for (int i = 0; i < N; i++) CL_REQ_ADDR[i*AW +: AW] = addr[i];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference state: memory contents, outstanding reads in acceptance order, RR pointer.
    typedef struct {
        int            id;
        logic [AW-1:0] a;
    } tag_t;

    logic [DW-1:0] mem [1<<AW];
    tag_t          mq[$];
    int            mptr = 0;
    logic [DW-1:0] bq[$];
    logic          s1_v = 1'b0;
    logic [DW-1:0] s1_d = '0;
    logic [N-1:0]  obs_req, obs_rsp;

    task automatic step(input logic rst, input logic [N-1:0] en, input logic rd_rdy,
                        input logic [N-1:0] will);
        int            winner;
        int            c;
        logic          rsp_valid;
        logic [N-1:0]  exp_req, exp_rsp, rsp_en;
        logic          dut_rd_en, dut_res_en;
        logic [AW-1:0] dut_rd_addr;
        tag_t          tdrop;
        logic [DW-1:0] ddrop;

        RST       = rst;
        CL_REQ_EN = en;
        RD_RDY    = rd_rdy;
        RES_RDY   = (bq.size() > 0);
        RES       = (bq.size() > 0) ? bq[0] : 32'hDEAD_BEEF;

        winner = -1;
        if (!rst && rd_rdy && mq.size() < MO) begin
            for (int k = 0; k < N; k++) begin
`ifdef BRAM_RD_ARB_RR_EN
                c = (mptr + k) % N;
`else
                c = k;
`endif
                if (winner < 0 && en[c]) winner = c;
            end
        end
        exp_req = '0;
        if (winner >= 0) exp_req[winner] = 1'b1;

        rsp_valid = !rst && RES_RDY && (mq.size() > 0);
        exp_rsp   = '0;
        rsp_en    = '0;
        if (rsp_valid) begin
            exp_rsp[mq[0].id] = 1'b1;
            if (will[mq[0].id]) rsp_en[mq[0].id] = 1'b1;
        end
        CL_RSP_EN = rsp_en;

        #2;
        chk("req_rdy", 64'(CL_REQ_RDY), 64'(exp_req));
        chk("rd_en", 64'(RD_EN), 64'(winner >= 0));
        if (winner >= 0) chk("rd_addr", 64'(RD_ADDR), 64'(addr[winner]));
        chk("rsp_rdy", 64'(CL_RSP_RDY), 64'(exp_rsp));
        chk("res_en", 64'(RES_EN), 64'(rsp_en != '0));
        if (rsp_valid) chk("rsp_data", 64'(CL_RSP), 64'(mem[mq[0].a]));
        obs_req     = CL_REQ_RDY;
        obs_rsp     = CL_RSP_RDY;
        dut_rd_en   = RD_EN;
        dut_rd_addr = RD_ADDR;
        dut_res_en  = RES_EN;

        @(posedge CLK);
        if (rst) begin
            mq.delete();
            bq.delete();
            s1_v = 1'b0;
            mptr = 0;
        end else begin
            if (dut_res_en && bq.size() > 0) ddrop = bq.pop_front();
            if (s1_v) bq.push_back(s1_d);
            s1_v = dut_rd_en;
            s1_d = mem[dut_rd_addr];
            if (rsp_en != '0) tdrop = mq.pop_front();
            if (winner >= 0) begin
                mq.push_back('{winner, addr[winner]});
                mptr = (winner + 1) % N;
            end
        end
        #1;
    endtask

    typedef struct {
        logic [N-1:0]  en;
        logic          rd_rdy;
        logic [N-1:0]  exp_rdy;
        logic          exp_rd_en;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vecs[6];
    int   gcnt[N];
    int   gexp[N];

    initial begin
        vecs[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 10'h100};
        vecs[1] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 10'h101};
        vecs[2] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 10'h103};
        vecs[3] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 10'h000};
        vecs[4] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 10'h000};
        vecs[5] = '{4'b1100, 1'b1, 4'b0100, 1'b1, 10'h102};

        for (int a = 0; a < (1 << AW); a++) mem[a] = $urandom;
        for (int i = 0; i < N; i++) begin
            mem[10'h10 + i] = 32'hA0 + i;
            addr[i] = AW'(10'h10 + i);
        end
        RST = 1'b1; CL_REQ_EN = '0; CL_RSP_EN = '0; RD_RDY = 1'b0; RES = '0; RES_RDY = 1'b0;
        @(posedge CLK); #1;

        // Reset held with every client requesting, then the first free cycle.
        repeat (3) begin
            step(1'b1, 4'b1111, 1'b1, 4'b1111);
            chk("rst_req_rdy", 64'(obs_req), 64'(0));
        end
        step(1'b0, 4'b1111, 1'b1, 4'b1111);
        chk("post_rst_grant", 64'(obs_req), 64'(4'b0001));

        for (int i = 0; i < N; i++) addr[i] = AW'(10'h100 + i);
        for (int v = 0; v < 6; v++) begin
            RST = 1'b1; CL_RSP_EN = '0; RES_RDY = 1'b0;
            @(posedge CLK); #1;
            RST = 1'b0;
            CL_REQ_EN = vecs[v].en;
            RD_RDY    = vecs[v].rd_rdy;
            #2;
            chk($sformatf("vec%0d_rdy", v), 64'(CL_REQ_RDY), 64'(vecs[v].exp_rdy));
            chk($sformatf("vec%0d_rd_en", v), 64'(RD_EN), 64'(vecs[v].exp_rd_en));
            if (vecs[v].exp_rd_en) chk($sformatf("vec%0d_addr", v), 64'(RD_ADDR), 64'(vecs[v].exp_addr));
        end

        // Continuous requests from all clients with immediate dequeue.
        for (int i = 0; i < N; i++) begin
            addr[i] = AW'(10'h10 + i);
            gcnt[i] = 0;
        end
        step(1'b1, 4'b0000, 1'b1, 4'b1111);
        repeat (24) begin
            step(1'b0, 4'b1111, 1'b1, 4'b1111);
            for (int i = 0; i < N; i++) if (obs_req[i]) gcnt[i]++;
        end
`ifdef BRAM_RD_ARB_RR_EN
        for (int i = 0; i < N; i++) gexp[i] = 4;
`else
        gexp[0] = 16;
        for (int i = 1; i < N; i++) gexp[i] = 0;
`endif
        for (int i = 0; i < N; i++) chk($sformatf("grants_c%0d", i), 64'(gcnt[i]), 64'(gexp[i]));
        repeat (3) step(1'b0, 4'b0000, 1'b1, 4'b1111);

        // Head-of-line: client 2 first, client 0 second, client 2 stalls.
        step(1'b1, 4'b0000, 1'b1, 4'b1111);
        step(1'b0, 4'b0100, 1'b1, 4'b0000);
        step(1'b0, 4'b0001, 1'b1, 4'b0000);
        repeat (5) begin
            step(1'b0, 4'b1111, 1'b1, 4'b1011);
            chk("hol_rsp_c0", 64'(obs_rsp[0]), 64'(0));
            chk("hol_req_rdy", 64'(obs_req), 64'(0));
        end
        step(1'b0, 4'b0000, 1'b1, 4'b1111);
        chk("hol_c2_release", 64'(obs_rsp), 64'(4'b0100));
        step(1'b0, 4'b0000, 1'b1, 4'b1111);
        chk("hol_c0_next", 64'(obs_rsp), 64'(4'b0001));

        // Request-side backpressure.
        step(1'b1, 4'b0000, 1'b1, 4'b1111);
        repeat (4) begin
            step(1'b0, 4'b1111, 1'b0, 4'b1111);
            chk("bp_req_rdy", 64'(obs_req), 64'(0));
        end
        step(1'b0, 4'b1111, 1'b1, 4'b1111);
        chk("bp_release", 64'(obs_req), 64'(4'b0001));
        repeat (4) step(1'b0, 4'b0000, 1'b1, 4'b1111);

        // Reset with two reads in flight.
        step(1'b1, 4'b0000, 1'b1, 4'b1111);
        step(1'b0, 4'b0010, 1'b1, 4'b0000);
        step(1'b0, 4'b1000, 1'b1, 4'b0000);
        step(1'b1, 4'b1111, 1'b1, 4'b1111);
        step(1'b0, 4'b0000, 1'b1, 4'b1111);
        chk("midrst_rsp_rdy", 64'(obs_rsp), 64'(0));
        step(1'b0, 4'b1111, 1'b1, 4'b1111);
        chk("midrst_ptr0", 64'(obs_req), 64'(4'b0001));
        repeat (4) step(1'b0, 4'b0000, 1'b1, 4'b1111);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic [N-1:0] will;
            for (int i = 0; i < N; i++) begin
                addr[i] = AW'($urandom);
                will[i] = ($urandom_range(0, 9) < 7);
            end
            step($urandom_range(0, 99) == 0, N'($urandom), $urandom_range(0, 9) < 8, will);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
